// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions: datapath width, generator polynomial and FSM state type.
package crc_pkg;

  localparam int CRC8_W = 8;
  localparam logic [CRC8_W-1:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_t;

endpackage

// File: rtl/crc8_lfsr_step.sv
// One MSB-first CRC-8 LFSR step: maps (crc, din) to the next remainder.
// Combinational, zero latency; no flow control, the caller decides when to register.
module crc8_lfsr_step
  import crc_pkg::*;
(
  input  logic [CRC8_W-1:0] crc,
  input  logic              din,
  output logic [CRC8_W-1:0] nxt
);

  logic fb;

  xorg u_fb (.a(crc[CRC8_W-1]), .b(din), .y(fb));

  assign nxt[0] = fb;

  // Each polynomial tap folds the feedback bit into the shifted value.
  for (genvar i = 1; i < CRC8_W; i++) begin : g_bit
    if (CRC8_POLY[i]) begin : g_tap
      xorg u_tap (.a(crc[i-1]), .b(fb), .y(nxt[i]));
    end else begin : g_shift
      assign nxt[i] = crc[i-1];
    end
  end

endmodule

// File: rtl/xorg.sv
// Two-input XOR gate, the shared feedback element of the gate-level datapath.
// Purely combinational, no flow control.
module xorg (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 generator/checker framed by start/last; remainder valid one edge after the last bit.
// No backpressure: every din_valid bit in SHIFT is absorbed; din_valid outside SHIFT is ignored.
module crc8_serial
  import crc_pkg::*;
#(
  parameter logic [CRC8_W-1:0] INIT  = 8'h00,
  parameter int                CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              din_valid,
  input  logic              din,
  input  logic              last,
  output logic [CRC8_W-1:0] crc,
  output logic              crc_valid,
  output logic              match,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_cnt
);

  crc_state_t        state, state_nxt;
  logic [CRC8_W-1:0] crc_step, crc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  crc8_lfsr_step u_step (.crc(crc), .din(din), .nxt(crc_step));

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    cnt_nxt   = bit_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SHIFT;
          crc_nxt   = INIT;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // A coincident bit is dropped on restart.
        if (start) begin
          crc_nxt = INIT;
          cnt_nxt = '0;
        end else if (din_valid) begin
          crc_nxt = crc_step;
          if (bit_cnt != '1) cnt_nxt = bit_cnt + CNT_W'(1);
          if (last) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= INIT;
      bit_cnt   <= '0;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      crc       <= crc_nxt;
      bit_cnt   <= cnt_nxt;
      crc_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == SHIFT);
    end
  end

  assign match = crc_valid && (crc == '0);

endmodule

// File: tb/tb_crc8_serial.sv
// Bench for crc8_serial: vector table, hand-built corner sequences, random messages vs polynomial division.
module tb_crc8_serial;

  logic       clk = 1'b0;
  logic       rst_n, start, din_valid, din, last;
  logic [7:0] crc, crc_s;
  logic       crc_valid, match, busy, cv_s, m_s, b_s;
  logic [15:0] bit_cnt;
  logic [2:0]  cnt_s;

  int errs = 0;
  int checks = 0;

  crc8_serial u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid), .din(din), .last(last),
    .crc(crc), .crc_valid(crc_valid), .match(match), .busy(busy), .bit_cnt(bit_cnt)
  );

  // Narrow counter copy, driven identically, exposes saturation in a short run.
  crc8_serial #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid), .din(din), .last(last),
    .crc(crc_s), .crc_valid(cv_s), .match(m_s), .busy(b_s), .bit_cnt(cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          nbits;
    logic [7:0]  exp_crc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; din_valid = 1'b0; din = 1'b0; last = 1'b0;
  endtask

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1 (init 0, no final XOR).
  function automatic logic [7:0] ref_crc(input bit q[$]);
    logic [8:0] rem = '0;
    bit b;
    for (int i = 0; i < q.size() + 8; i++) begin
      b = (i < q.size()) ? q[i] : 1'b0;
      rem = {rem[7:0], b};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // Frames one message; when b2b is set it returns in the DONE cycle so the caller can chain.
  task automatic send_msg(input bit q[$], input logic [7:0] exp, input int gap_pct, input bit b2b,
                          input string tag);
    int n = q.size();
    start = 1'b1; din_valid = 1'b0; last = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    chk({tag, " crc after start"}, crc, 8'h00);
    chk({tag, " cnt after start"}, bit_cnt, 0);
    chk({tag, " no valid after start"}, crc_valid, 0);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        din_valid = 1'b0; din = 1'($urandom); last = 1'($urandom);
        tick();
        chk({tag, " busy in gap"}, busy, 1);
      end
      din_valid = 1'b1; din = q[i]; last = (i == n - 1);
      tick();
      if (i != n - 1) chk({tag, " busy mid"}, busy, 1);
    end
    idle_in();
    chk({tag, " crc_valid"}, crc_valid, 1);
    chk({tag, " crc"}, crc, exp);
    chk({tag, " match"}, match, (exp == 8'h00));
    chk({tag, " bit_cnt"}, bit_cnt, n);
    chk({tag, " busy done"}, busy, 0);
    chk({tag, " sat cnt"}, cnt_s, (n > 7) ? 7 : n);
    chk({tag, " sat crc"}, crc_s, exp);
    if (!b2b) begin
      tick();
      chk({tag, " valid drops"}, crc_valid, 0);
      chk({tag, " crc holds"}, crc, exp);
      chk({tag, " match drops"}, match, 0);
    end
  endtask

  initial begin
    vec_t vecs[7];
    bit   q[$];
    logic [7:0] ascii[9];
    int   len;

    vecs[0] = '{16'h0080, 8,  8'h89};
    vecs[1] = '{16'h0001, 8,  8'h07};
    vecs[2] = '{16'h0000, 8,  8'h00};
    vecs[3] = '{16'h0107, 16, 8'h00};
    vecs[4] = '{16'h00FF, 8,  8'hF3};
    vecs[5] = '{16'h0001, 1,  8'h07};
    vecs[6] = '{16'h0000, 1,  8'h00};

    rst_n = 1'b0;
    idle_in();
    tick(); tick();
    chk("reset crc", crc, 8'h00);
    chk("reset cnt", bit_cnt, 0);
    chk("reset valid", crc_valid, 0);
    chk("reset match", match, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[v]) begin
      q = {};
      for (int k = vecs[v].nbits - 1; k >= 0; k--) q.push_back(vecs[v].data[k]);
      send_msg(q, vecs[v].exp_crc, 0, 1'b0, $sformatf("vec%0d", v));
    end

    // IDLE ignores din_valid; outputs keep the last remainder.
    din_valid = 1'b1; din = 1'b1; last = 1'b1;
    repeat (3) tick();
    idle_in();
    chk("idle crc hold", crc, 8'h00);
    chk("idle cnt hold", bit_cnt, 1);
    chk("idle busy", busy, 0);
    chk("idle no valid", crc_valid, 0);

    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    q = {};
    foreach (ascii[b]) for (int k = 7; k >= 0; k--) q.push_back(ascii[b][k]);
    send_msg(q, 8'hF4, 40, 1'b0, "ascii");

    // Restart after 5 bits with a coincident bit that must be discarded.
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) begin
      din_valid = 1'b1; din = 1'b1; tick();
    end
    start = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick();
    start = 1'b0;
    chk("restart crc", crc, 8'h00);
    chk("restart cnt", bit_cnt, 0);
    chk("restart busy", busy, 1);
    for (int k = 7; k >= 0; k--) begin
      din_valid = 1'b1; din = (k == 0); last = (k == 0); tick();
    end
    idle_in();
    chk("restart valid", crc_valid, 1);
    chk("restart final crc", crc, 8'h07);
    chk("restart final cnt", bit_cnt, 8);
    tick();

    // Back-to-back: start lands in the DONE cycle of the first message.
    q = {};
    for (int k = 7; k >= 0; k--) q.push_back(k == 7);
    send_msg(q, 8'h89, 0, 1'b1, "b2b first");
    q = {};
    for (int k = 0; k < 8; k++) q.push_back(1'b0);
    send_msg(q, 8'h00, 0, 1'b0, "b2b second");

    // Reset mid-message aborts without a crc_valid pulse.
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) begin
      din_valid = 1'b1; din = 1'b1; tick();
    end
    chk("pre-reset crc nonzero", (crc != 8'h00), 1);
    din_valid = 1'b1; last = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset crc", crc, 8'h00);
    chk("async reset cnt", bit_cnt, 0);
    chk("async reset busy", busy, 0);
    chk("async reset valid", crc_valid, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post-reset no valid", crc_valid, 0);
      chk("post-reset cnt", bit_cnt, 0);
      chk("post-reset busy", busy, 0);
    end
    idle_in();
    tick();

    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(40, 1);
      q = {};
      for (int k = 0; k < len; k++) q.push_back(1'($urandom));
      send_msg(q, ref_crc(q), 30, (r % 3) == 0, $sformatf("rand%0d", r));
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
